// File: rtl/hazard_stall_unit.sv
// ID-stage hazard detector: stalls PC and IF/ID and bubbles ID/EX.
// Load-to-branch costs two cycles; all other hazards cost one.
module hazard_stall_unit #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid_id,
    input  logic                   flush_id,
    input  logic [6:0]             opcode_id,
    input  logic [4:0]             rs1_id,
    input  logic [4:0]             rs2_id,
    input  logic [4:0]             rd_ex,
    input  logic                   reg_write_ex,
    input  logic                   mem_read_ex,
    input  logic [4:0]             rd_mem,
    input  logic                   mem_read_mem,
    output logic                   stall,
    output logic                   pc_en,
    output logic                   if_id_en,
    output logic                   id_ex_flush,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;

    typedef enum logic [1:0] {RUN, STALL2, RELEASE} state_t;

    state_t state, state_nxt;
    logic   use_rs1, use_rs2, is_br;
    logic   ex1, ex2, mem1, mem2;
    logic   ld1, ld2, hz2, hz1;
    logic   stall_c;

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        is_br   = 1'b0;
        case (opcode_id)
            OP_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                is_br   = 1'b1;
            end
            OP_STORE, OP_OP: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_JALR: begin
                use_rs1 = 1'b1;
                is_br   = 1'b1;
            end
            OP_LOAD, OP_OPIMM: use_rs1 = 1'b1;
            default: ;
        endcase
    end

    assign ex1  = use_rs1 && reg_write_ex && rd_ex == rs1_id && rs1_id != 5'd0;
    assign ex2  = use_rs2 && reg_write_ex && rd_ex == rs2_id && rs2_id != 5'd0;
    assign mem1 = use_rs1 && mem_read_mem && rd_mem == rs1_id && rs1_id != 5'd0;
    assign mem2 = use_rs2 && mem_read_mem && rd_mem == rs2_id && rs2_id != 5'd0;
    assign ld1  = mem_read_ex && ex1;
    assign ld2  = mem_read_ex && ex2;

    assign hz2 = valid_id && is_br && (ld1 || ld2);
    assign hz1 = valid_id && !hz2 &&
                 (is_br ? (ex1 || ex2 || mem1 || mem2) : (ld1 || ld2));

    // Flush kills the held instruction, so any pending stall is moot.
    always_comb begin
        state_nxt = state;
        stall_c   = 1'b0;
        if (flush_id) begin
            state_nxt = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (hz2) begin
                        stall_c   = 1'b1;
                        state_nxt = STALL2;
                    end else if (hz1) begin
                        stall_c   = 1'b1;
                        state_nxt = RELEASE;
                    end
                end
                STALL2: begin
                    stall_c   = 1'b1;
                    state_nxt = RELEASE;
                end
                RELEASE: state_nxt = RUN;
                default: state_nxt = RUN;
            endcase
        end
    end

    assign stall       = stall_c && !reset;
    assign pc_en       = !stall;
    assign if_id_en    = !stall;
    assign id_ex_flush = stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            stall_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: stall-budget model plus directed vectors.
// A narrow-counter instance shares the stimulus to exercise saturation.
module tb_hazard_stall_unit;

    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] ST   = 7'b0100011;
    localparam logic [6:0] OPR  = 7'b0110011;
    localparam logic [6:0] JALR = 7'b1100111;
    localparam logic [6:0] LD   = 7'b0000011;
    localparam logic [6:0] OPI  = 7'b0010011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] LUI  = 7'b0110111;
    localparam logic [6:0] AUI  = 7'b0010111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_id = 1'b0, flush_id = 1'b0;
    logic [6:0]  opcode_id = '0;
    logic [4:0]  rs1_id = '0, rs2_id = '0, rd_ex = '0, rd_mem = '0;
    logic        reg_write_ex = 1'b0, mem_read_ex = 1'b0, mem_read_mem = 1'b0;
    logic        stall, pc_en, if_id_en, id_ex_flush;
    logic [15:0] stall_cnt;
    logic        stall4, pc_en4, if_id_en4, id_ex_flush4;
    logic [3:0]  stall_cnt4;

    int checks = 0;
    int failures = 0;
    bit run_cmp = 1'b0;

    // Model state: cycles of forced stall still owed, then one release.
    int owed = 0;
    bit rel = 1'b0;
    int mcnt = 0;
    int mcnt4 = 0;

    hazard_stall_unit #(.STALL_CNT_W(16)) dut (
        .clk(clk), .reset(reset), .valid_id(valid_id), .flush_id(flush_id),
        .opcode_id(opcode_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rd_ex(rd_ex), .reg_write_ex(reg_write_ex), .mem_read_ex(mem_read_ex),
        .rd_mem(rd_mem), .mem_read_mem(mem_read_mem),
        .stall(stall), .pc_en(pc_en), .if_id_en(if_id_en),
        .id_ex_flush(id_ex_flush), .stall_cnt(stall_cnt)
    );

    hazard_stall_unit #(.STALL_CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .valid_id(valid_id), .flush_id(flush_id),
        .opcode_id(opcode_id), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rd_ex(rd_ex), .reg_write_ex(reg_write_ex), .mem_read_ex(mem_read_ex),
        .rd_mem(rd_mem), .mem_read_mem(mem_read_mem),
        .stall(stall4), .pc_en(pc_en4), .if_id_en(if_id_en4),
        .id_ex_flush(id_ex_flush4), .stall_cnt(stall_cnt4)
    );

    always #5 clk = ~clk;

    function automatic int cost();
        bit u1, u2, br, ld_hit, any_hit;
        u1 = 0; u2 = 0;
        br = (opcode_id == BR) || (opcode_id == JALR);
        if (opcode_id inside {BR, ST, OPR}) begin u1 = 1; u2 = 1; end
        if (opcode_id inside {JALR, LD, OPI}) u1 = 1;
        ld_hit = 0; any_hit = 0;
        for (int k = 0; k < 2; k++) begin
            logic [4:0] r;
            bit u;
            r = (k == 0) ? rs1_id : rs2_id;
            u = (k == 0) ? u1 : u2;
            if (u && r != 0) begin
                if (reg_write_ex && mem_read_ex && rd_ex == r) ld_hit = 1;
                if (reg_write_ex && rd_ex == r) any_hit = 1;
                if (mem_read_mem && rd_mem == r) any_hit = 1;
            end
        end
        if (br && ld_hit) return 2;
        if (br && any_hit) return 1;
        if (!br && ld_hit) return 1;
        return 0;
    endfunction

    function automatic bit model_stall();
        if (reset || flush_id) return 0;
        if (owed > 0) return 1;
        if (rel) return 0;
        return valid_id && cost() > 0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            owed <= 0; rel <= 0; mcnt <= 0; mcnt4 <= 0;
        end else begin
            if (model_stall()) begin
                mcnt  <= (mcnt == 65535) ? mcnt : mcnt + 1;
                mcnt4 <= (mcnt4 == 15) ? mcnt4 : mcnt4 + 1;
            end
            if (flush_id) begin
                owed <= 0; rel <= 0;
            end else if (owed > 0) begin
                owed <= owed - 1; rel <= 1;
            end else if (rel) begin
                rel <= 0;
            end else if (valid_id) begin
                if (cost() == 2) owed <= 1;
                else if (cost() == 1) rel <= 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run_cmp) begin
            bit es;
            es = model_stall();
            chk("m_stall", 32'(stall), 32'(es));
            chk("m_pc_en", 32'(pc_en), 32'(!es));
            chk("m_if_id_en", 32'(if_id_en), 32'(!es));
            chk("m_id_ex_flush", 32'(id_ex_flush), 32'(es));
            chk("m_cnt", 32'(stall_cnt), 32'(mcnt));
            chk("m_stall4", 32'(stall4), 32'(es));
            chk("m_cnt4", 32'(stall_cnt4), 32'(mcnt4));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rdx, input logic rw, input logic mr,
                         input logic [4:0] rdm, input logic mrm);
        valid_id = 1; flush_id = 0; opcode_id = op; rs1_id = r1; rs2_id = r2;
        rd_ex = rdx; reg_write_ex = rw; mem_read_ex = mr; rd_mem = rdm; mem_read_mem = mrm;
    endtask

    task automatic nop();
        valid_id = 0; flush_id = 0; opcode_id = '0; rs1_id = '0; rs2_id = '0;
        rd_ex = '0; reg_write_ex = 0; mem_read_ex = 0; rd_mem = '0; mem_read_mem = 0;
    endtask

    task automatic do_reset();
        reset = 1; cyc(); reset = 0; nop();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        nop();
        cyc();
        run_cmp = 1;
        @(negedge clk);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_pc_en", 32'(pc_en), 1);
        chk("rst_cnt", 32'(stall_cnt), 0);
        cyc(); reset = 0;

        // lw x5 ; beq x5,x6 -> two stall cycles then release
        drive(BR, 5, 6, 5, 1, 1, 0, 0);
        @(negedge clk); chk("t1_c1", 32'(stall), 1);
        cyc(); @(negedge clk); chk("t1_c2", 32'(stall), 1);
        cyc(); @(negedge clk); chk("t1_c3", 32'(stall), 0);
        chk("t1_cnt", 32'(stall_cnt), 2);
        cyc(); nop(); cyc();

        // add x7 ; beq x1,x7 -> one stall
        do_reset();
        drive(BR, 1, 7, 7, 1, 0, 0, 0);
        @(negedge clk); chk("t2_c1", 32'(stall), 1);
        cyc(); @(negedge clk); chk("t2_c2", 32'(stall), 0);
        chk("t2_cnt", 32'(stall_cnt), 1);
        cyc(); nop(); cyc();

        // load in MEM feeding branch, load in EX feeding jalr
        drive(BR, 9, 2, 4, 1, 0, 9, 1); repeat (3) cyc();
        nop(); cyc();
        drive(JALR, 6, 0, 6, 1, 1, 0, 0); repeat (3) cyc();
        nop(); cyc();

        // lw x3 ; add x4,x3,x2 -> one stall
        do_reset();
        drive(OPR, 3, 2, 3, 1, 1, 0, 0);
        @(negedge clk); chk("t3_c1", 32'(stall), 1);
        cyc(); @(negedge clk); chk("t3_c2", 32'(stall), 0);
        cyc();
        drive(OPI, 2, 3, 3, 1, 1, 0, 0);
        @(negedge clk); chk("t3_addi", 32'(stall), 0);
        cyc();
        drive(ST, 1, 3, 3, 1, 1, 0, 0); repeat (2) cyc();
        drive(OPR, 3, 2, 3, 1, 0, 3, 1); cyc();
        drive(OPR, 3, 2, 3, 1, 1, 0, 0); valid_id = 0; cyc();

        // x0 never hazards; jal/lui/auipc never stall
        drive(BR, 0, 0, 0, 1, 1, 0, 1);
        @(negedge clk); chk("t4_x0", 32'(stall), 0);
        cyc();
        drive(JAL, 5, 5, 5, 1, 1, 5, 1);
        @(negedge clk); chk("t4_jal", 32'(stall), 0);
        cyc();
        drive(LUI, 5, 5, 5, 1, 1, 5, 1);
        @(negedge clk); chk("t4_lui", 32'(stall), 0);
        cyc();
        drive(AUI, 5, 5, 5, 1, 1, 5, 1);
        @(negedge clk); chk("t4_auipc", 32'(stall), 0);
        cyc(); nop(); cyc();

        // flush in second stall cycle
        do_reset();
        drive(BR, 5, 6, 5, 1, 1, 0, 0);
        @(negedge clk); chk("t5_c1", 32'(stall), 1);
        cyc(); flush_id = 1;
        @(negedge clk); chk("t5_flush", 32'(stall), 0);
        chk("t5_pc_en", 32'(pc_en), 1);
        cyc(); flush_id = 0;
        @(negedge clk); chk("t5_run", 32'(stall), 1);
        cyc(); nop(); repeat (2) cyc();

        // reset in STALL2
        drive(BR, 5, 6, 5, 1, 1, 0, 0);
        cyc(); @(negedge clk); chk("t5_s2", 32'(stall), 1);
        #2 reset = 1;
        #1 chk("t5_rst_stall", 32'(stall), 0);
        chk("t5_rst_cnt", 32'(stall_cnt), 0);
        chk("t5_rst_if_id", 32'(if_id_en), 1);
        cyc(); reset = 0; nop(); cyc();

        // 20 load-use stalls saturate the 4-bit counter
        do_reset();
        drive(OPR, 3, 2, 3, 1, 1, 0, 0);
        repeat (40) cyc();
        nop();
        @(negedge clk);
        chk("t6_cnt16", 32'(stall_cnt), 20);
        chk("t6_cnt4", 32'(stall_cnt4), 15);
        cyc(); cyc();

        run_cmp = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
